// File: rtl/odd_pipe_pkg.sv
// Shared odd-pipe definitions: instruction field layout, decoded register fields
// and the round-robin pointer encoding.
package odd_pipe_pkg;

   localparam int unsigned RF_ADDR_W = 7;
   localparam int unsigned INST_W    = 32;
   localparam int unsigned OPC_W     = 11;

   // Fields are numbered big-endian: bit 0 is the opcode MSB.
   localparam int unsigned OPC_POS = 0;
   localparam int unsigned RB_POS  = 11;
   localparam int unsigned RA_POS  = 18;
   localparam int unsigned RT_POS  = 25;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] rt;
      logic [RF_ADDR_W-1:0] ra;
      logic [RF_ADDR_W-1:0] rb;
   } inst_fields_t;

   typedef enum logic {
      RR_PORT0 = 1'b0,
      RR_PORT1 = 1'b1
   } rr_ptr_t;

   function automatic inst_fields_t get_fields(input logic [0:INST_W-1] inst);
      inst_fields_t f;
      f.rt = inst[RT_POS +: RF_ADDR_W];
      f.ra = inst[RA_POS +: RF_ADDR_W];
      f.rb = inst[RB_POS +: RF_ADDR_W];
      return f;
   endfunction

endpackage

// File: rtl/perm_scoreboard.sv
// In-flight destination FIFO for the permute pipe: per-requester hazard compare,
// occupancy count and in-order completion check.
module perm_scoreboard
   import odd_pipe_pkg::*;
#(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned CNT_W = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 push,
   input  logic [RF_ADDR_W-1:0] push_rt,
   input  logic                 pop,
   input  logic [RF_ADDR_W-1:0] pop_rt,
   input  inst_fields_t         q0,
   input  inst_fields_t         q1,
   output logic                 haz0,
   output logic                 haz1,
   output logic                 full,
   output logic [CNT_W-1:0]     count,
   output logic                 err_cpl
);

   logic [RF_ADDR_W-1:0] ent [DEPTH];
   logic                 do_pop;
   logic                 do_push;
   logic [CNT_W-1:0]     wr_idx;

   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & (count != '0);
   assign do_push = push & (do_pop | ~full);
   assign wr_idx  = count - CNT_W'(do_pop);

   // Entries below count are live; an entry popped this cycle still blocks.
   always_comb begin
      haz0 = 1'b0;
      haz1 = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count) begin
            if (ent[i] == q0.rt || ent[i] == q0.ra || ent[i] == q0.rb) haz0 = 1'b1;
            if (ent[i] == q1.rt || ent[i] == q1.ra || ent[i] == q1.rb) haz1 = 1'b1;
         end
      end
   end

   // Collapsing FIFO: head always sits at ent[0].
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count   <= '0;
         err_cpl <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else begin
         if (pop && (count == '0 || ent[0] != pop_rt)) err_cpl <= 1'b1;
         if (clear) begin
            count <= '0;
         end else begin
            if (do_pop) begin
               for (int unsigned i = 0; i + 1 < DEPTH; i++) ent[i] <= ent[i+1];
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (do_push && CNT_W'(i) == wr_idx) ent[i] <= push_rt;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         end
      end
   end

endmodule

// File: rtl/permute_issue_ctrl.sv
// Odd-pipe issue scheduler for permute_unit: two-port round-robin arbitration,
// hazard stall against in-flight ops, issue register and flush handling.
module permute_issue_ctrl
   import odd_pipe_pkg::*;
#(
   parameter int unsigned PIPE_DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            req0_valid,
   input  logic [0:INST_W-1]               req0_inst,
   input  logic                            req0_op_11,
   output logic                            req0_ready,
   input  logic                            req1_valid,
   input  logic [0:INST_W-1]               req1_inst,
   input  logic                            req1_op_11,
   output logic                            req1_ready,
   input  logic                            flush,
   output logic                            permute_unit_sel,
   output logic                            op_11_odd,
   output logic [0:INST_W-1]               inst_odd,
   output logic [RF_ADDR_W-1:0]            odd_ra_addr,
   output logic [RF_ADDR_W-1:0]            odd_rb_addr,
   output logic                            unit_reset,
   input  logic                            premute_out_availible,
   input  logic [RF_ADDR_W-1:0]            permute_addr_rt,
   output logic [$clog2(PIPE_DEPTH+2)-1:0] inflight_cnt,
   output logic                            illegal_op,
   output logic                            err_cpl
);

   localparam int unsigned DEPTH = PIPE_DEPTH + 1;
   localparam int unsigned CNT_W = $clog2(PIPE_DEPTH + 2);
   localparam int unsigned IGN_W = $clog2(PIPE_DEPTH + 1);

   inst_fields_t      f0, f1, win_f;
   logic              haz0, haz1, full, room;
   logic              elig0, elig1, gnt0, gnt1, grant;
   logic              cpl_en, win_op11;
   logic [0:INST_W-1] win_inst;
   logic [IGN_W-1:0]  ign_cnt;
   rr_ptr_t           rr_ptr;

   assign f0 = get_fields(req0_inst);
   assign f1 = get_fields(req1_inst);

   // Stale strobes from the flushed unit are dropped for PIPE_DEPTH cycles.
   assign cpl_en = premute_out_availible & ~flush & (ign_cnt == '0);
   // A completion in the same cycle frees the slot, keeping a full pipe streaming.
   assign room   = ~full | cpl_en;
   assign elig0  = req0_valid & ~haz0 & ~flush & room;
   assign elig1  = req1_valid & ~haz1 & ~flush & room;

   always_comb begin
      gnt0 = elig0 & (~elig1 | (rr_ptr == RR_PORT0));
      gnt1 = elig1 & (~elig0 | (rr_ptr == RR_PORT1));
   end

   assign grant      = gnt0 | gnt1;
   assign req0_ready = gnt0 & reset;
   assign req1_ready = gnt1 & reset;
   assign win_inst   = gnt1 ? req1_inst  : req0_inst;
   assign win_op11   = gnt1 ? req1_op_11 : req0_op_11;
   assign win_f      = gnt1 ? f1 : f0;

   perm_scoreboard #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_sb (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .push    (grant & win_op11),
      .push_rt (win_f.rt),
      .pop     (cpl_en),
      .pop_rt  (permute_addr_rt),
      .q0      (f0),
      .q1      (f1),
      .haz0    (haz0),
      .haz1    (haz1),
      .full    (full),
      .count   (inflight_cnt),
      .err_cpl (err_cpl)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr           <= RR_PORT0;
         ign_cnt          <= '0;
         unit_reset       <= 1'b0;
         illegal_op       <= 1'b0;
         permute_unit_sel <= 1'b0;
         op_11_odd        <= 1'b0;
         inst_odd         <= '0;
         odd_ra_addr      <= '0;
         odd_rb_addr      <= '0;
      end else begin
         unit_reset <= flush;
         if (flush)             ign_cnt <= IGN_W'(PIPE_DEPTH);
         else if (ign_cnt != '0) ign_cnt <= ign_cnt - 1'b1;

         if (gnt0)      rr_ptr <= RR_PORT1;
         else if (gnt1) rr_ptr <= RR_PORT0;

         illegal_op <= grant & ~win_op11;
         if (grant && win_op11) begin
            permute_unit_sel <= 1'b1;
            op_11_odd        <= 1'b1;
            inst_odd         <= win_inst;
            odd_ra_addr      <= win_f.ra;
            odd_rb_addr      <= win_f.rb;
         end else begin
            permute_unit_sel <= 1'b0;
            op_11_odd        <= 1'b0;
            inst_odd         <= '0;
            odd_ra_addr      <= '0;
            odd_rb_addr      <= '0;
         end
      end
   end

endmodule

// File: tb/tb_permute_issue_ctrl.sv
// Directed self-checking bench for permute_issue_ctrl (PIPE_DEPTH = 2).
module tb_permute_issue_ctrl;
   import odd_pipe_pkg::*;

   localparam logic [OPC_W-1:0] OPC_SHLQBI = 11'h1DB;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 req0_valid, req0_op_11, req0_ready;
   logic                 req1_valid, req1_op_11, req1_ready;
   logic [0:INST_W-1]    req0_inst, req1_inst, inst_odd;
   logic                 flush, permute_unit_sel, op_11_odd, unit_reset;
   logic [RF_ADDR_W-1:0] odd_ra_addr, odd_rb_addr, permute_addr_rt;
   logic                 premute_out_availible, illegal_op, err_cpl;
   logic [1:0]           inflight_cnt;

   int checks   = 0;
   int failures = 0;

   permute_issue_ctrl #(.PIPE_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_inst(req0_inst), .req0_op_11(req0_op_11), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_inst(req1_inst), .req1_op_11(req1_op_11), .req1_ready(req1_ready),
      .flush(flush), .permute_unit_sel(permute_unit_sel), .op_11_odd(op_11_odd), .inst_odd(inst_odd),
      .odd_ra_addr(odd_ra_addr), .odd_rb_addr(odd_rb_addr), .unit_reset(unit_reset),
      .premute_out_availible(premute_out_availible), .permute_addr_rt(permute_addr_rt),
      .inflight_cnt(inflight_cnt), .illegal_op(illegal_op), .err_cpl(err_cpl)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [0:INST_W-1] mk(input int unsigned rt, input int unsigned ra, input int unsigned rb);
      logic [0:INST_W-1] v;
      v = '0;
      v[OPC_POS +: OPC_W]    = OPC_SHLQBI;
      v[RT_POS +: RF_ADDR_W] = RF_ADDR_W'(rt);
      v[RA_POS +: RF_ADDR_W] = RF_ADDR_W'(ra);
      v[RB_POS +: RF_ADDR_W] = RF_ADDR_W'(rb);
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req0_valid = 1'b0; req0_inst = '0; req0_op_11 = 1'b1;
      req1_valid = 1'b0; req1_inst = '0; req1_op_11 = 1'b1;
      flush = 1'b0; premute_out_availible = 1'b0; permute_addr_rt = '0;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      idle_inputs();
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset;
      idle_inputs();
      reset = 1'b0;
      req0_valid = 1'b1; req0_inst = mk(1, 2, 3);
      #2;
      checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL rst_ready0 got=%0h exp=0", req0_ready); end
      checks++; if (permute_unit_sel !== 1'b0) begin failures++; $display("FAIL rst_sel got=%0h exp=0", permute_unit_sel); end
      checks++; if (inst_odd !== '0) begin failures++; $display("FAIL rst_inst got=%0h exp=0", inst_odd); end
      checks++; if (inflight_cnt !== 2'd0) begin failures++; $display("FAIL rst_cnt got=%0h exp=0", inflight_cnt); end
      checks++; if ({unit_reset, illegal_op, err_cpl, op_11_odd} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%0h exp=0", {unit_reset, illegal_op, err_cpl, op_11_odd}); end
      do_reset();
   endtask

   task automatic test_single_issue;
      logic [0:INST_W-1] a;
      do_reset();
      a = mk(5, 3, 4);
      req0_valid = 1'b1; req0_inst = a;
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL t1_ready0 got=%0h exp=1", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL t1_ready1 got=%0h exp=0", req1_ready); end
      tick();
      req0_valid = 1'b0;
      checks++; if (permute_unit_sel !== 1'b1) begin failures++; $display("FAIL t1_sel got=%0h exp=1", permute_unit_sel); end
      checks++; if (inst_odd !== a) begin failures++; $display("FAIL t1_inst got=%0h exp=%0h", inst_odd, a); end
      checks++; if (op_11_odd !== 1'b1) begin failures++; $display("FAIL t1_op11 got=%0h exp=1", op_11_odd); end
      checks++; if (odd_ra_addr !== 7'd3 || odd_rb_addr !== 7'd4) begin failures++; $display("FAIL t1_addr got=%0d/%0d exp=3/4", odd_ra_addr, odd_rb_addr); end
      checks++; if (inflight_cnt !== 2'd1) begin failures++; $display("FAIL t1_cnt got=%0d exp=1", inflight_cnt); end
      tick();
      checks++; if (permute_unit_sel !== 1'b0 || inst_odd !== '0) begin failures++; $display("FAIL t1_idle got=%0h/%0h exp=0/0", permute_unit_sel, inst_odd); end
      tick();
      premute_out_availible = 1'b1; permute_addr_rt = 7'd5;
      tick();
      premute_out_availible = 1'b0;
      checks++; if (inflight_cnt !== 2'd0) begin failures++; $display("FAIL t1_cnt_done got=%0d exp=0", inflight_cnt); end
      checks++; if (err_cpl !== 1'b0) begin failures++; $display("FAIL t1_err got=%0h exp=0", err_cpl); end
   endtask

   task automatic test_back_to_back;
      logic [0:INST_W-1]    seq [8];
      logic [RF_ADDR_W-1:0] seq_rt [8];
      logic                 exp0, exp1;
      int                   i0, i1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         seq[2*i]      = mk(20 + i, 40 + i, 50 + i);
         seq_rt[2*i]   = RF_ADDR_W'(20 + i);
         seq[2*i+1]    = mk(30 + i, 60 + i, 70 + i);
         seq_rt[2*i+1] = RF_ADDR_W'(30 + i);
      end
      i0 = 0; i1 = 0;
      for (int c = 0; c < 11; c++) begin
         req0_valid = (i0 < 4); req0_inst = (i0 < 4) ? seq[2*i0]   : '0;
         req1_valid = (i1 < 4); req1_inst = (i1 < 4) ? seq[2*i1+1] : '0;
         premute_out_availible = (c >= 3);
         permute_addr_rt       = (c >= 3) ? seq_rt[c-3] : '0;
         if (c >= 1 && c <= 8) begin
            checks++; if (permute_unit_sel !== 1'b1 || inst_odd !== seq[c-1]) begin failures++; $display("FAIL b2b_issue c=%0d got=%0h/%0h exp=1/%0h", c, permute_unit_sel, inst_odd, seq[c-1]); end
         end else begin
            checks++; if (permute_unit_sel !== 1'b0) begin failures++; $display("FAIL b2b_nosel c=%0d got=%0h exp=0", c, permute_unit_sel); end
         end
         exp0 = (c < 8) && (c % 2 == 0);
         exp1 = (c < 8) && (c % 2 == 1);
         #1;
         checks++; if (req0_ready !== exp0 || req1_ready !== exp1) begin failures++; $display("FAIL b2b_grant c=%0d got=%0b%0b exp=%0b%0b", c, req0_ready, req1_ready, exp0, exp1); end
         if (exp0) i0++;
         if (exp1) i1++;
         tick();
      end
      idle_inputs();
      checks++; if (inflight_cnt !== 2'd0 || err_cpl !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0d/%0h exp=0/0", inflight_cnt, err_cpl); end
   endtask

   task automatic test_hazard;
      logic [0:INST_W-1] z;
      do_reset();
      z = mk(14, 10, 15);
      req0_valid = 1'b1; req0_inst = mk(10, 1, 2);
      tick();
      req0_inst = mk(11, 12, 13);
      req1_valid = 1'b1; req1_inst = z;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL haz_c1 got=%0b%0b exp=10", req0_ready, req1_ready); end
      tick();
      req0_valid = 1'b0;
      #1;
      checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL haz_c2 got=%0h exp=0", req1_ready); end
      tick();
      premute_out_availible = 1'b1; permute_addr_rt = 7'd10;
      #1;
      checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL haz_c3 got=%0h exp=0", req1_ready); end
      tick();
      permute_addr_rt = 7'd11;
      #1;
      checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL haz_c4 got=%0h exp=1", req1_ready); end
      tick();
      premute_out_availible = 1'b0; req1_valid = 1'b0;
      checks++; if (permute_unit_sel !== 1'b1 || inst_odd !== z || inflight_cnt !== 2'd1) begin failures++; $display("FAIL haz_issue got=%0h/%0h/%0d exp=1/%0h/1", permute_unit_sel, inst_odd, inflight_cnt, z); end
      tick();
      tick();
      premute_out_availible = 1'b1; permute_addr_rt = 7'd14;
      tick();
      premute_out_availible = 1'b0;
      checks++; if (inflight_cnt !== 2'd0 || err_cpl !== 1'b0) begin failures++; $display("FAIL haz_end got=%0d/%0h exp=0/0", inflight_cnt, err_cpl); end
   endtask

   task automatic test_flush;
      do_reset();
      req0_valid = 1'b1; req0_inst = mk(1, 2, 3);
      tick();
      req0_inst = mk(4, 5, 6);
      tick();
      req0_inst = mk(7, 8, 9); flush = 1'b1;
      checks++; if (inflight_cnt !== 2'd2) begin failures++; $display("FAIL fl_cnt2 got=%0d exp=2", inflight_cnt); end
      #1;
      checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL fl_nogrant got=%0h exp=0", req0_ready); end
      tick();
      flush = 1'b0; req0_valid = 1'b0;
      premute_out_availible = 1'b1; permute_addr_rt = 7'd1;
      checks++; if (unit_reset !== 1'b1 || inflight_cnt !== 2'd0 || permute_unit_sel !== 1'b0) begin failures++; $display("FAIL fl_f1 got=%0h/%0d/%0h exp=1/0/0", unit_reset, inflight_cnt, permute_unit_sel); end
      tick();
      permute_addr_rt = 7'd4;
      checks++; if (unit_reset !== 1'b0) begin failures++; $display("FAIL fl_pulse got=%0h exp=0", unit_reset); end
      tick();
      premute_out_availible = 1'b0;
      checks++; if (inflight_cnt !== 2'd0 || err_cpl !== 1'b0) begin failures++; $display("FAIL fl_ignored got=%0d/%0h exp=0/0", inflight_cnt, err_cpl); end
      req0_valid = 1'b1; req0_inst = mk(7, 8, 9);
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL fl_regrant got=%0h exp=1", req0_ready); end
      tick();
      req0_valid = 1'b0;
      checks++; if (inflight_cnt !== 2'd1 || permute_unit_sel !== 1'b1) begin failures++; $display("FAIL fl_reissue got=%0d/%0h exp=1/1", inflight_cnt, permute_unit_sel); end
      flush = 1'b1;
      tick();
      checks++; if (unit_reset !== 1'b1 || inflight_cnt !== 2'd0) begin failures++; $display("FAIL fl_hold1 got=%0h/%0d exp=1/0", unit_reset, inflight_cnt); end
      tick();
      flush = 1'b0;
      checks++; if (unit_reset !== 1'b1) begin failures++; $display("FAIL fl_hold2 got=%0h exp=1", unit_reset); end
      tick();
      checks++; if (unit_reset !== 1'b0 || err_cpl !== 1'b0) begin failures++; $display("FAIL fl_release got=%0h/%0h exp=0/0", unit_reset, err_cpl); end
   endtask

   task automatic test_bad_cpl;
      do_reset();
      req0_valid = 1'b1; req0_inst = mk(5, 3, 4);
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      premute_out_availible = 1'b1; permute_addr_rt = 7'd7;
      checks++; if (err_cpl !== 1'b0) begin failures++; $display("FAIL bad_pre got=%0h exp=0", err_cpl); end
      tick();
      premute_out_availible = 1'b0;
      checks++; if (err_cpl !== 1'b1 || inflight_cnt !== 2'd0) begin failures++; $display("FAIL bad_set got=%0h/%0d exp=1/0", err_cpl, inflight_cnt); end
      tick();
      tick();
      checks++; if (err_cpl !== 1'b1) begin failures++; $display("FAIL bad_sticky got=%0h exp=1", err_cpl); end
   endtask

   task automatic test_illegal_and_async_reset;
      logic [0:INST_W-1] w;
      do_reset();
      checks++; if (err_cpl !== 1'b0) begin failures++; $display("FAIL ill_errclr got=%0h exp=0", err_cpl); end
      req0_valid = 1'b1; req0_op_11 = 1'b0; req0_inst = mk(2, 3, 4);
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL ill_ready got=%0h exp=1", req0_ready); end
      tick();
      req0_valid = 1'b0; req0_op_11 = 1'b1;
      checks++; if (illegal_op !== 1'b1 || permute_unit_sel !== 1'b0 || inflight_cnt !== 2'd0) begin failures++; $display("FAIL ill_pulse got=%0h/%0h/%0d exp=1/0/0", illegal_op, permute_unit_sel, inflight_cnt); end
      tick();
      checks++; if (illegal_op !== 1'b0) begin failures++; $display("FAIL ill_end got=%0h exp=0", illegal_op); end
      req0_valid = 1'b1;
      tick();
      checks++; if (permute_unit_sel !== 1'b1 || inflight_cnt !== 2'd1) begin failures++; $display("FAIL ar_pre got=%0h/%0d exp=1/1", permute_unit_sel, inflight_cnt); end
      w = mk(9, 10, 11);
      req0_inst = w;
      #2;
      reset = 1'b0;
      #1;
      checks++; if (permute_unit_sel !== 1'b0 || inst_odd !== '0 || inflight_cnt !== 2'd0 || req0_ready !== 1'b0) begin failures++; $display("FAIL ar_clear got=%0h/%0h/%0d/%0h exp=0/0/0/0", permute_unit_sel, inst_odd, inflight_cnt, req0_ready); end
      reset = 1'b1;
      tick();
      req0_valid = 1'b0;
      checks++; if (permute_unit_sel !== 1'b1 || inst_odd !== w) begin failures++; $display("FAIL ar_first got=%0h/%0h exp=1/%0h", permute_unit_sel, inst_odd, w); end
   endtask

   initial begin
      test_reset();
      test_single_issue();
      test_back_to_back();
      test_hazard();
      test_flush();
      test_bad_cpl();
      test_illegal_and_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
